// File: rtl/riscv_fetch_unit.sv
// Instruction fetch front end: PC, credit-limited imem requests, in-order response FIFO to decode.
// Response to if_* is 1 cycle; requests stall when outstanding + buffered reaches DEPTH or on redirect.
module riscv_fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              DEPTH    = 2
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            if_valid,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_instr,
    input  logic            if_ready
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] resp_pc_q, resp_pc_d;
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [CW-1:0]   drop_q, drop_d;
    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [XLEN-1:0] fifo_pc_q    [DEPTH];
    logic [XLEN-1:0] fifo_instr_q [DEPTH];

    logic [XLEN-1:0] redirect_tgt;
    logic [CW:0]     in_flight;
    logic            req_fire;
    logic            push;
    logic            pop;
    logic            unused_lsbs;

    assign unused_lsbs  = ^redirect_pc[1:0];
    assign redirect_tgt = {redirect_pc[XLEN-1:2], 2'b00};

    // Credit covers both in-flight words and buffered words, so the FIFO can never overflow.
    assign in_flight      = {1'b0, outstanding_q} + {1'b0, count_q};
    assign imem_req_valid = !reset && !redirect_valid && (in_flight < DEPTH_C);
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign if_valid = (count_q != '0);
    assign if_pc    = if_valid ? fifo_pc_q[rd_ptr_q]    : '0;
    assign if_instr = if_valid ? fifo_instr_q[rd_ptr_q] : '0;

    assign push = imem_rsp_valid && (drop_q == '0) && !redirect_valid;
    assign pop  = if_valid && if_ready;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        outstanding_d = outstanding_q + CW'(req_fire) - CW'(imem_rsp_valid);
        drop_d        = drop_q;
        count_d       = count_q + CW'(push) - CW'(pop);
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;

        if (req_fire) begin
            fetch_pc_d = fetch_pc_q + XLEN'(4);
        end
        if (imem_rsp_valid && (drop_q != '0)) begin
            drop_d = drop_q - CW'(1);
        end
        if (push) begin
            wr_ptr_d  = wr_ptr_q + PW'(1);
            resp_pc_d = resp_pc_q + XLEN'(4);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end

        // Every request still in flight is wrong-path; a response landing now is discarded too.
        if (redirect_valid) begin
            fetch_pc_d = redirect_tgt;
            resp_pc_d  = redirect_tgt;
            drop_d     = outstanding_q - CW'(imem_rsp_valid);
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            drop_q        <= '0;
            count_q       <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
            count_q       <= count_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && push) begin
            assert ({1'b0, count_q} < DEPTH_C);
            fifo_pc_q[wr_ptr_q]    <= resp_pc_q;
            fifo_instr_q[wr_ptr_q] <= imem_rsp_data;
        end
    end

endmodule

// File: doc/riscv_fetch_unit.md
Name: riscv_fetch_unit

Overview:
- Instruction-fetch front end that sits directly upstream of datapath_RISCV.
- Owns the program counter and issues word requests to instruction memory over a valid/ready request channel with an in-order response channel.
- Buffers returned instructions in a small FIFO and presents them to the decode stage with a valid/ready handshake.
- Accepts branch/jump redirects from execute, flushing all wrong-path state.

Parameters:
- XLEN, 32, data and address width.
- RESET_PC, 32'h0000_0000, PC loaded on reset (bits [1:0] must be 0).
- DEPTH, 2, instruction FIFO entries and maximum outstanding requests (power of 2, >=2).

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_addr  out  XLEN  byte address of requested word, bits [1:0] always 0.
- imem_req_ready  in  1  memory accepts request this cycle.
- imem_rsp_valid  in  1  response word valid; responses return in request order, at least 1 cycle after acceptance.
- imem_rsp_data  in  XLEN  instruction word.
- redirect_valid  in  1  execute-stage redirect (taken branch/jump).
- redirect_pc  in  XLEN  redirect target; bits [1:0] ignored and treated as 0.
- if_valid  out  1  instruction available to decode.
- if_pc  out  XLEN  PC of the presented instruction.
- if_instr  out  XLEN  presented instruction.
- if_ready  in  1  decode accepts the instruction this cycle.

Behaviour:
- Reset (sampled high at a rising edge):
  - fetch_pc = RESET_PC; FIFO empty; outstanding = 0; drop = 0.
  - Outputs: imem_req_valid = 0, if_valid = 0, if_pc = 0, if_instr = 0.
  - Reset overrides every other input in the same cycle, including mid-transaction; responses to pre-reset requests are the memory's responsibility (memory shares the reset).
- Credit:
  - imem_req_valid = !reset && !redirect_valid && (outstanding + fifo_count) < DEPTH; imem_req_addr = fetch_pc.
  - A request is accepted when imem_req_valid && imem_req_ready. Acceptance increments outstanding and advances fetch_pc by 4, wrapping mod 2^XLEN (32'hFFFF_FFFC -> 0).
  - A request held with ready low keeps the same address; valid never drops while credit remains and no redirect occurs.
- Response:
  - Each imem_rsp_valid decrements outstanding.
  - If drop > 0, the word is discarded and drop decrements.
  - Otherwise {fetch-order PC, data} is pushed to the FIFO. The PC is tracked via a resp_pc register that advances by 4 per kept response and is loaded with the new PC on redirect.
  - The credit rule guarantees the FIFO never overflows; push into a full FIFO is an assertion failure.
- Decode side:
  - if_valid = FIFO non-empty; if_pc/if_instr = head entry. Outputs stay stable while if_valid && !if_ready.
  - Pop on if_valid && if_ready. Push and pop in the same cycle are both honoured; count is unchanged.
  - A response arriving to an empty FIFO appears on if_* the next cycle (1-cycle latency). Zero-latency bypass is not allowed.
- Redirect (highest priority after reset):
  - FIFO flushed (if_valid = 0 next cycle); fetch_pc = resp_pc = {redirect_pc[XLEN-1:2], 2'b00}.
  - drop = outstanding minus any response arriving that same cycle; that same-cycle response is also discarded.
  - No request is issued in the redirect cycle. First request to the new PC is made in the following cycle.
  - A pop in the redirect cycle is honoured (decode consumed it) but the entry is flushed regardless.
  - Back-to-back redirects: the latest wins; drop accumulates correctly.
- Steady state with 1-cycle memory and if_ready = 1: one instruction per cycle on if_*, first one 2 cycles after the first request is accepted.
- State summary (no explicit FSM): fetch_pc, resp_pc, outstanding [log2(DEPTH):0], drop [log2(DEPTH):0], FIFO with rd/wr pointers and count.

Test Plan:
- Reset then 1-cycle memory returning addr^32'hA5A5_0000, if_ready = 1 -> requests to 0,4,8,C… on consecutive cycles; if_pc = 0,4,8 with if_instr = 32'hA5A5_0000, 32'hA5A5_0004, …; no bubbles after the first.
- if_ready held low for 5 cycles -> after 2 accepted responses imem_req_valid = 0; if_pc stays 0; on release, 0,4,8 delivered in order with no loss or duplicates.
- imem_req_ready low for 3 cycles on addr 8 -> imem_req_addr holds 8, imem_req_valid stays 1; fetch_pc advances only on acceptance.
- Redirect to 32'h0000_0103 with 2 requests outstanding -> both responses dropped; next request addr 32'h0000_0100; first if_pc = 0x100; no stale instruction ever shown.
- Redirect in the same cycle as a response and a decode pop -> that response is discarded, FIFO is empty next cycle, and the following request is to the target.
- Redirect to 32'hFFFF_FFF8 -> fetch addresses FFFF_FFF8, FFFF_FFFC, 0000_0000; reset asserted mid-stream -> if_valid = 0 next cycle and refetch from RESET_PC.
